// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    // Largest number of read ports the register file is built for.
    localparam int REGFILE_MAX_NREAD = 8;

    // Bit offset of lane 'lane' inside a flattened bus of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write bus of the multi-port register file.
// The master (decode/writeback side) drives addresses, enables and write data.
// The slave (register file) returns read data and the write-conflict flag.
// Optional feature macro: REGFILE_BYPASS_EN (used by the slave only).
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] ReadRegister;
    logic [NREAD*DATA_W-1:0] ReadData;
    logic                    RegWrite0;
    logic [ADDR_W-1:0]       WriteRegister0;
    logic [DATA_W-1:0]       WriteData0;
    logic                    RegWrite1;
    logic [ADDR_W-1:0]       WriteRegister1;
    logic [DATA_W-1:0]       WriteData1;
    logic                    WriteConflict;

    modport master (
        output ReadRegister,
        output RegWrite0, WriteRegister0, WriteData0,
        output RegWrite1, WriteRegister1, WriteData1,
        input  ReadData,
        input  WriteConflict
    );

    modport slave (
        input  ReadRegister,
        input  RegWrite0, WriteRegister0, WriteData0,
        input  RegWrite1, WriteRegister1, WriteData1,
        output ReadData,
        output WriteConflict
    );
endinterface

// File: rtl/regfile_read_port.sv
// One asynchronous read port: address -> word mux, register-0 zero gating and,
// when REGFILE_BYPASS_EN is defined, same-cycle forwarding of the write data
// (write port 1 takes priority over write port 0).
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic [ADDR_W-1:0] raddr,
`ifdef REGFILE_BYPASS_EN
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
`endif
    output logic [DATA_W-1:0] rdata
);

    // Select the stored word, override with in-flight write data, then gate r0.
    always_comb begin
        // NOTE: rdata gets a default on entry so every path assigns it and no latch is inferred.
        rdata = mem[raddr];
`ifdef REGFILE_BYPASS_EN
        if (we0 && (waddr0 == raddr)) rdata = wdata0;
        if (we1 && (waddr1 == raddr)) rdata = wdata1;
`endif
        if ((ZERO_REG != 0) && (raddr == '0)) rdata = '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: 2**ADDR_W words of DATA_W bits, NREAD
// asynchronous read ports, two synchronous write ports. On a same-address
// write collision port 1 wins and WriteConflict is raised for one cycle.
// ZERO_REG=1 hardwires register 0 to zero.
// Optional feature macro: REGFILE_BYPASS_EN (reads see same-cycle writes).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         Clk,
    input  logic         Reset_n,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic collide;
    logic wr0_en;
    logic wr1_en;
    logic wr0_zero;
    logic wr1_zero;

    // Decide which write ports actually update storage this cycle.
    always_comb begin
        collide  = bus.RegWrite0 && bus.RegWrite1 &&
                   (bus.WriteRegister0 == bus.WriteRegister1);
        wr0_zero = (ZERO_REG != 0) && (bus.WriteRegister0 == '0);
        wr1_zero = (ZERO_REG != 0) && (bus.WriteRegister1 == '0);
        wr1_en   = bus.RegWrite1 && !wr1_zero;
        wr0_en   = bus.RegWrite0 && !wr0_zero && !collide;
    end

    // Storage update: only the addressed words change, everything clears on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: the whole array is reset, so it maps to flops rather than a RAM macro; that is intended.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep every reader seeing the pre-edge contents.
            if (wr0_en) mem[bus.WriteRegister0] <= bus.WriteData0;
            if (wr1_en) mem[bus.WriteRegister1] <= bus.WriteData1;
        end
    end

    // Collision flag, valid for the cycle after the colliding edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.WriteConflict <= 1'b0;
        end else begin
            bus.WriteConflict <= collide;
        end
    end

    // One read port per lane; unsupported port counts read as zero.
    if ((NREAD >= 1) && (NREAD <= REGFILE_MAX_NREAD)) begin : g_ports
        for (genvar i = 0; i < NREAD; i++) begin : g_rd
            regfile_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_rd (
                .mem    (mem),
                .raddr  (bus.ReadRegister[lane_lsb(i, ADDR_W) +: ADDR_W]),
`ifdef REGFILE_BYPASS_EN
                .we0    (bus.RegWrite0),
                .waddr0 (bus.WriteRegister0),
                .wdata0 (bus.WriteData0),
                .we1    (bus.RegWrite1),
                .waddr1 (bus.WriteRegister1),
                .wdata1 (bus.WriteData1),
`endif
                .rdata  (bus.ReadData[lane_lsb(i, DATA_W) +: DATA_W])
            );
        end
    end else begin : g_ports_unsupported
        assign bus.ReadData = '0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp.
// dut_a: NREAD=4, ZERO_REG=1. dut_b: NREAD=2, ZERO_REG=0.
// Expectations around same-cycle reads follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic Clk;
    logic Reset_n;
    int   errors;
    int   checks;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(4)) bus_a ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus_b ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(4), .ZERO_REG(1)) dut_a (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_a)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(0)) dut_b (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic e1, input logic [4:0] a1, input logic [31:0] d1);
        bus_a.RegWrite0 = e0; bus_a.WriteRegister0 = a0; bus_a.WriteData0 = d0;
        bus_a.RegWrite1 = e1; bus_a.WriteRegister1 = a1; bus_a.WriteData1 = d1;
    endtask

    task automatic rd_addr(input int lane, input logic [4:0] a);
        bus_a.ReadRegister[lane*5 +: 5] = a;
    endtask

    function automatic logic [31:0] rd(input int lane);
        return bus_a.ReadData[lane*32 +: 32];
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        Reset_n = 1'b0;
        bus_a.ReadRegister = '0;
        wr_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus_b.ReadRegister = '0;
        bus_b.RegWrite0 = 1'b0; bus_b.WriteRegister0 = '0; bus_b.WriteData0 = '0;
        bus_b.RegWrite1 = 1'b0; bus_b.WriteRegister1 = '0; bus_b.WriteData1 = '0;

        // Reset state.
        #12 Reset_n = 1'b1;
        rd_addr(0, 5'd1); rd_addr(1, 5'd31); rd_addr(2, 5'd5); rd_addr(3, 5'd16);
        #1;
        check("reset_rd0", rd(0), 32'd0);
        check("reset_rd1", rd(1), 32'd0);
        check("reset_conflict", {31'd0, bus_a.WriteConflict}, 32'd0);

        // Write then overwrite r2, read on ports 0 and 1.
        step();
        rd_addr(0, 5'd2); rd_addr(1, 5'd2);
        wr_a(1'b1, 5'd2, 32'd42, 1'b0, 5'd0, 32'd0);
        step();
        check("r2_42_p0", rd(0), 32'd42);
        check("r2_42_p1", rd(1), 32'd42);
        wr_a(1'b1, 5'd2, 32'd15, 1'b0, 5'd0, 32'd0);
        step();
        check("r2_15_p0", rd(0), 32'd15);
        check("r2_15_p1", rd(1), 32'd15);

        // Disabled write has no effect; enabled write touches only its word.
        wr_a(1'b0, 5'd2, 32'd12, 1'b0, 5'd2, 32'd99);
        step();
        check("r2_hold_disabled", rd(0), 32'd15);
        rd_addr(1, 5'd3); rd_addr(2, 5'd4);
        wr_a(1'b1, 5'd2, 32'd12, 1'b0, 5'd0, 32'd0);
        step();
        check("r2_12", rd(0), 32'd12);
        check("r3_untouched", rd(1), 32'd0);
        check("r4_untouched", rd(2), 32'd0);

        // Same-address collision: port 1 wins, flag for one cycle.
        rd_addr(0, 5'd7); rd_addr(1, 5'd8); rd_addr(2, 5'd9);
        wr_a(1'b1, 5'd7, 32'd5, 1'b1, 5'd7, 32'd9);
        step();
        check("collide_r7", rd(0), 32'd9);
        check("collide_flag", {31'd0, bus_a.WriteConflict}, 32'd1);
        wr_a(1'b1, 5'd8, 32'd1, 1'b1, 5'd9, 32'd2);
        step();
        check("distinct_flag", {31'd0, bus_a.WriteConflict}, 32'd0);
        check("distinct_r8", rd(1), 32'd1);
        check("distinct_r9", rd(2), 32'd2);
        check("r7_still_9", rd(0), 32'd9);

        // Register 0: hardwired in dut_a, ordinary in dut_b; collision on r0 still flags.
        rd_addr(0, 5'd0);
        wr_a(1'b1, 5'd0, 32'd12, 1'b0, 5'd0, 32'd0);
        bus_b.ReadRegister[4:0] = 5'd0;
        bus_b.RegWrite0 = 1'b1; bus_b.WriteRegister0 = 5'd0; bus_b.WriteData0 = 32'd12;
        step();
        check("zero_reg_r0", rd(0), 32'd0);
        check("plain_r0", bus_b.ReadData[31:0], 32'd12);
        bus_b.RegWrite0 = 1'b0;
        wr_a(1'b1, 5'd0, 32'd3, 1'b1, 5'd0, 32'd4);
        step();
        check("zero_collide_flag", {31'd0, bus_a.WriteConflict}, 32'd1);
        check("zero_collide_r0", rd(0), 32'd0);

        // Four read ports, two of them on the same word.
        wr_a(1'b1, 5'd2, 32'd2, 1'b1, 5'd17, 32'd47);
        rd_addr(0, 5'd2); rd_addr(1, 5'd17); rd_addr(2, 5'd0); rd_addr(3, 5'd2);
        step();
        check("np4_rd0", rd(0), 32'd2);
        check("np4_rd1", rd(1), 32'd47);
        check("np4_rd2", rd(2), 32'd0);
        check("np4_rd3", rd(3), 32'd2);

        // Same-cycle read of a word being written.
        wr_a(1'b1, 5'd3, 32'd77, 1'b0, 5'd0, 32'd0);
        rd_addr(0, 5'd3);
        #1;
        check("same_cycle_r3_pre", rd(0), BYP ? 32'd77 : 32'd0);
        step();
        check("same_cycle_r3_post", rd(0), 32'd77);
        wr_a(1'b1, 5'd6, 32'd1, 1'b1, 5'd6, 32'd3);
        rd_addr(0, 5'd6);
        #1;
        check("same_cycle_r6_pre", rd(0), BYP ? 32'd3 : 32'd0);
        wr_a(1'b1, 5'd0, 32'd55, 1'b0, 5'd0, 32'd0);
        rd_addr(1, 5'd0);
        #1;
        check("same_cycle_r0_pre", rd(1), 32'd0);
        step();
        check("same_cycle_r0_post", rd(1), 32'd0);

        // Mid-run reset with a conflict flag set and a colliding write pending.
        wr_a(1'b1, 5'd5, 32'd42, 1'b0, 5'd0, 32'd0);
        step();
        wr_a(1'b1, 5'd10, 32'd1, 1'b1, 5'd10, 32'd2);
        rd_addr(0, 5'd5); rd_addr(1, 5'd10); rd_addr(2, 5'd2); rd_addr(3, 5'd7);
        step();
        check("pre_reset_r5", rd(0), 32'd42);
        check("pre_reset_flag", {31'd0, bus_a.WriteConflict}, 32'd1);
        wr_a(1'b1, 5'd11, 32'd8, 1'b1, 5'd11, 32'd9);
        #2 Reset_n = 1'b0;
        #1;
        check("in_reset_r5", rd(0), 32'd0);
        check("in_reset_r10", rd(1), 32'd0);
        check("in_reset_r2", rd(2), 32'd0);
        check("in_reset_flag", {31'd0, bus_a.WriteConflict}, 32'd0);
        check("in_reset_b_r0", bus_b.ReadData[31:0], 32'd0);
        step();
        check("reset_edge_r7", rd(3), 32'd0);
        check("reset_edge_flag", {31'd0, bus_a.WriteConflict}, 32'd0);
        wr_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rd_addr(0, 5'd11);
        #3 Reset_n = 1'b1;
        #1;
        check("post_reset_r11", rd(0), 32'd0);
        step();
        check("post_reset_flag", {31'd0, bus_a.WriteConflict}, 32'd0);
        check("post_reset_r10", rd(1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
